dh_session_endpoint: RTL and testbench
======================================

Name: dh_session_endpoint

Overview:
- Parametrised next-generation drone/command-centre key-exchange endpoint.
- Runs one Diffie-Hellman exchange:
  - computes own public part g^secret mod p;
  - exchanges it with the peer;
  - derives the shared key peer_pub^secret mod p.
- Then streams messages through XOR encryption until the session is closed.
- Adds over the previous block: generic widths, valid/ready handshakes, peer timeout, parameter checking, multi-message sessions, a single time-shared exponentiator.

Parameters:
- KW, 8: width of g, p, secret, public parts and key.
- MW, 64: message/ciphertext width; key replicated LSB-first across MW, truncated.
- TIMEOUT, 1024: WAIT_PEER cycle limit; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ena  in  1  global enable; low freezes all state, outputs hold
- start  in  1  pulse: begin session (sampled in IDLE only)
- secret  in  KW  private exponent, captured on start
- g  in  KW  generator, captured on start
- p  in  KW  modulus, captured on start
- pub_out  out  KW  own public part
- pub_valid  out  1  level: pub_out valid for the rest of the session
- peer_pub  in  KW  peer public part
- peer_valid  in  1  peer_pub valid (first one per session is captured)
- msg_in  in  MW  plaintext
- msg_valid  in  1  plaintext valid
- msg_ready  out  1  high in READY only
- ct_out  out  MW  ciphertext, held until the next one
- ct_valid  out  1  one-cycle pulse per ciphertext
- close  in  1  pulse: end session, clear key
- busy  out  1  high in any state except IDLE
- timeout_err  out  1  one-cycle pulse on peer timeout
- cfg_err  out  1  one-cycle pulse when p<2 at start

Behaviour:
- Reset: all outputs 0; FSM to IDLE; key, pub, peer and timeout counter registers cleared. rst mid-operation aborts the session with no error pulse.
- ena=0: no register changes anywhere (including the sub-module); inputs arriving during that cycle are ignored.
- FSM states: IDLE, GEN_PUB, WAIT_PEER, GEN_KEY, READY.
- IDLE:
  - start with p<2: pulse cfg_err, stay in IDLE.
  - start with p≥2: capture secret/g/p, launch the exponentiator (base g), go to GEN_PUB.
  - start in any other state is ignored.
- GEN_PUB:
  - On exponentiator rdy, register the result into pub_out.
  - Assert pub_valid, go to WAIT_PEER.
  - pub_valid rises exactly KW+2 cycles after the start edge.
- Peer capture:
  - peer_valid is captured in any non-IDLE state (early arrival is kept).
  - Only the first capture per session counts.
- WAIT_PEER:
  - With a peer captured (this cycle or earlier): launch the exponentiator (base peer_pub), go to GEN_KEY.
  - Otherwise count. If TIMEOUT≠0 and the count reaches TIMEOUT: pulse timeout_err, go to IDLE, pub_valid drops.
- GEN_KEY: on rdy, register the key, go to READY. The key is internal and never output.
- READY:
  - msg_ready=1. On msg_valid: ct_out = msg_in XOR keystream, ct_valid pulses on the next edge. Throughput is 1 message/cycle.
  - close: go to IDLE, clear key/pub/peer, pub_valid=0.
  - close and msg_valid together: the message is encrypted, then the FSM goes to IDLE.
- close outside READY: ignored.
- Arithmetic:
  - Products are 2·KW bits, reduced mod p.
  - Base is reduced mod p before the first step.
  - secret=0 gives result 1.
  - peer_pub≥p is accepted and reduced.

Decomposition:
- Shared package dh_pkg:
  - state enum;
  - KW/MW defaults;
  - function replicating a KW key to MW.
- Sub-module modexp (parameter W):
  - inputs clk, rst, ena, start, base, exp, mod; outputs res, rdy;
  - right-to-left square-and-multiply, one exponent bit per cycle;
  - rdy is a one-cycle pulse exactly W+1 cycles after start;
  - start while running restarts it.
- One modexp instance, time-shared between GEN_PUB and GEN_KEY.

Test Plan:
- Public part: KW=8, g=5, p=23, secret=6, start -> pub_out=8, pub_valid high exactly 10 cycles after start.
- Key and encryption:
  - then peer_pub=19 -> key=2;
  - msg_in=0x0123456789ABCDEF -> ct_out=0x032147658BA9CFED, ct_valid pulses once;
  - back-to-back messages give one ciphertext per cycle.
- Timeout: TIMEOUT=16, no peer_valid -> timeout_err pulses 16 cycles after entering WAIT_PEER; busy=0 and pub_valid=0 next cycle.
- Early peer and ordering: peer_valid during GEN_PUB with peer_pub=19 -> key still 2; a second peer_valid=7 is ignored.
- Config error and freeze: p=1 -> cfg_err pulse, busy stays 0; ena low 5 cycles mid GEN_PUB -> pub_valid delayed exactly 5 cycles.
- Reset and close: rst in GEN_KEY -> all outputs 0 next cycle; close with msg_valid in READY -> that ct produced, then busy=0, msg_ready=0.

Source files
------------

// File: rtl/dh_pkg.sv
// dh_pkg: shared state encoding, default widths and key-to-keystream replication.
package dh_pkg;
  typedef enum logic [2:0] {IDLE, GEN_PUB, WAIT_PEER, GEN_KEY, READY} state_t;
  localparam int DEF_KW = 8;
  localparam int DEF_MW = 64;
  localparam int KMAX = 256;
  localparam int MMAX = 1024;
  function automatic logic [MMAX-1:0] rep_key(input logic [KMAX-1:0] k, input int kw);
    logic [MMAX-1:0] r;
    r = '0;
    for (int i = 0; i < MMAX; i++) r[i] = k[i % kw];
    return r;
  endfunction
endpackage

// File: rtl/modexp.sv
// modexp: right-to-left square-and-multiply, one exponent bit per cycle, rdy W+1 cycles after start.
module modexp #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ena,
  input  logic         start,
  input  logic [W-1:0] base,
  input  logic [W-1:0] exp,
  input  logic [W-1:0] mod,
  output logic [W-1:0] res,
  output logic         rdy
);
  localparam int CW = $clog2(W + 1);
  logic [W-1:0] b, e, m;
  logic [CW-1:0] cnt;
  logic run;
  function automatic logic [W-1:0] mulmod(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] md);
    return W'(({{W{1'b0}}, x} * {{W{1'b0}}, y}) % {{W{1'b0}}, md});
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      res <= '0;
      b <= '0;
      e <= '0;
      m <= '0;
      cnt <= '0;
      run <= 1'b0;
      rdy <= 1'b0;
    end else if (ena) begin
      rdy <= 1'b0;
      if (start) begin
        res <= W'(1);
        b <= base % mod;
        e <= exp;
        m <= mod;
        cnt <= CW'(W);
        run <= 1'b1;
      end else if (run) begin
        if (cnt != '0) begin
          if (e[0]) res <= mulmod(res, b, m);
          b <= mulmod(b, b, m);
          e <= e >> 1;
          cnt <= cnt - 1'b1;
        end else begin
          rdy <= 1'b1;
          run <= 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/dh_session_endpoint.sv
// dh_session_endpoint: one Diffie-Hellman exchange on a shared exponentiator, then XOR message streaming.
import dh_pkg::*;
module dh_session_endpoint #(
  parameter int KW = DEF_KW,
  parameter int MW = DEF_MW,
  parameter int TIMEOUT = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ena,
  input  logic          start,
  input  logic [KW-1:0] secret,
  input  logic [KW-1:0] g,
  input  logic [KW-1:0] p,
  output logic [KW-1:0] pub_out,
  output logic          pub_valid,
  input  logic [KW-1:0] peer_pub,
  input  logic          peer_valid,
  input  logic [MW-1:0] msg_in,
  input  logic          msg_valid,
  output logic          msg_ready,
  output logic [MW-1:0] ct_out,
  output logic          ct_valid,
  input  logic          close,
  output logic          busy,
  output logic          timeout_err,
  output logic          cfg_err
);
  state_t state;
  logic [KW-1:0] sec_r, p_r, peer_r, key;
  logic peer_have;
  logic [31:0] cnt;
  logic launch_pub, launch_key, mx_rdy;
  logic [KW-1:0] mx_base, mx_exp, mx_mod, mx_res;
  logic [MW-1:0] ks;
  assign launch_pub = state == IDLE && start && p > KW'(1);
  assign launch_key = state == WAIT_PEER && (peer_have || peer_valid);
  // the exponentiator loads straight from the ports on start so pub lands KW+2 cycles later
  assign mx_base = launch_pub ? g : (peer_have ? peer_r : peer_pub);
  assign mx_exp = launch_pub ? secret : sec_r;
  assign mx_mod = launch_pub ? p : p_r;
  assign ks = MW'(rep_key(KMAX'(key), KW));
  assign busy = state != IDLE;
  assign msg_ready = state == READY;
  modexp #(.W(KW)) u_modexp (
    .clk(clk), .rst(rst), .ena(ena), .start(launch_pub || launch_key),
    .base(mx_base), .exp(mx_exp), .mod(mx_mod), .res(mx_res), .rdy(mx_rdy)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sec_r <= '0;
      p_r <= '0;
      peer_r <= '0;
      key <= '0;
      peer_have <= 1'b0;
      cnt <= '0;
      pub_out <= '0;
      pub_valid <= 1'b0;
      ct_out <= '0;
      ct_valid <= 1'b0;
      timeout_err <= 1'b0;
      cfg_err <= 1'b0;
    end else if (ena) begin
      ct_valid <= 1'b0;
      timeout_err <= 1'b0;
      cfg_err <= 1'b0;
      if (state != IDLE && peer_valid && !peer_have) begin
        peer_have <= 1'b1;
        peer_r <= peer_pub;
      end
      case (state)
        IDLE: begin
          peer_have <= 1'b0;
          cnt <= '0;
          if (launch_pub) begin
            sec_r <= secret;
            p_r <= p;
            state <= GEN_PUB;
          end else if (start) cfg_err <= 1'b1;
        end
        GEN_PUB: if (mx_rdy) begin
          pub_out <= mx_res;
          pub_valid <= 1'b1;
          state <= WAIT_PEER;
        end
        WAIT_PEER: begin
          if (launch_key) state <= GEN_KEY;
          else if (TIMEOUT != 0 && cnt == 32'(TIMEOUT - 1)) begin
            timeout_err <= 1'b1;
            pub_valid <= 1'b0;
            pub_out <= '0;
            state <= IDLE;
          end else cnt <= cnt + 1'b1;
        end
        GEN_KEY: if (mx_rdy) begin
          key <= mx_res;
          state <= READY;
        end
        READY: begin
          if (msg_valid) begin
            ct_out <= msg_in ^ ks;
            ct_valid <= 1'b1;
          end
          if (close) begin
            state <= IDLE;
            key <= '0;
            pub_out <= '0;
            pub_valid <= 1'b0;
            peer_have <= 1'b0;
            peer_r <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dh_session_endpoint.sv
// tb_dh_session_endpoint: directed scenarios with hand-computed DH results (g=5, p=23, secret=6, peer=19 -> pub 8, key 2).
module tb_dh_session_endpoint;
  logic clk = 0, rst = 0, ena = 1, start = 0, peer_valid = 0, msg_valid = 0, close = 0;
  logic [7:0] secret = 0, g = 0, p = 0, peer_pub = 0, pub_out;
  logic [63:0] msg_in = 0, ct_out;
  logic pub_valid, msg_ready, ct_valid, busy, timeout_err, cfg_err;
  int n_checks = 0, n_fail = 0;
  localparam logic [63:0] KS2 = 64'h0202020202020202;

  dh_session_endpoint #(.KW(8), .MW(64), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ena(ena), .start(start), .secret(secret), .g(g), .p(p),
    .pub_out(pub_out), .pub_valid(pub_valid), .peer_pub(peer_pub), .peer_valid(peer_valid),
    .msg_in(msg_in), .msg_valid(msg_valid), .msg_ready(msg_ready), .ct_out(ct_out),
    .ct_valid(ct_valid), .close(close), .busy(busy), .timeout_err(timeout_err), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic start_sess(input logic [7:0] gg, input logic [7:0] pp, input logic [7:0] ss);
    g = gg; p = pp; secret = ss; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    n_checks++;
    if ({pub_out, pub_valid, msg_ready, ct_out, ct_valid, busy, timeout_err, cfg_err} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0", {pub_out, pub_valid, msg_ready, ct_out, ct_valid, busy, timeout_err, cfg_err});
    end
  endtask

  task automatic test_pub_key();
    logic [63:0] msgs [3] = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h1122334455667788};
    int k;
    start_sess(5, 23, 6);
    for (int i = 1; i <= 11; i++) begin
      if (i > 1) @(negedge clk);
      n_checks++;
      if (pub_valid !== (i == 11)) begin n_fail++; $display("FAIL pub_valid_timing: cycle %0d got %b want %b", i, pub_valid, i == 11); end
    end
    n_checks++;
    if (pub_out !== 8'd8) begin n_fail++; $display("FAIL pub_out: got %0d want 8", pub_out); end
    peer_pub = 19; peer_valid = 1;
    @(negedge clk);
    peer_valid = 0;
    for (k = 0; k < 40 && !msg_ready; k++) @(negedge clk);
    n_checks++;
    if (k !== 10) begin n_fail++; $display("FAIL key_latency: got %0d cycles want 10", k); end
    msg_in = 64'h0123456789ABCDEF; msg_valid = 1;
    @(negedge clk);
    msg_valid = 0;
    n_checks++;
    if (ct_out !== 64'h032147658BA9CFED || ct_valid !== 1'b1) begin n_fail++; $display("FAIL encrypt: got %h/%b want 032147658ba9cfed/1", ct_out, ct_valid); end
    @(negedge clk);
    n_checks++;
    if (ct_valid !== 1'b0 || ct_out !== 64'h032147658BA9CFED) begin n_fail++; $display("FAIL ct_pulse: got %h/%b want held ct, valid 0", ct_out, ct_valid); end
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin msg_in = msgs[i]; msg_valid = 1; end else msg_valid = 0;
      @(negedge clk);
      if (i > 0 || i == 0) begin
        n_checks++;
        if (i < 3 && (ct_out !== (msgs[i] ^ KS2) || ct_valid !== 1'b1)) begin n_fail++; $display("FAIL back_to_back[%0d]: got %h/%b want %h/1", i, ct_out, ct_valid, msgs[i] ^ KS2); end
        else if (i == 3 && ct_valid !== 1'b0) begin n_fail++; $display("FAIL back_to_back_end: got valid %b want 0", ct_valid); end
      end
    end
    msg_in = 64'hFFFFFFFFFFFFFFFF; msg_valid = 1; close = 1;
    @(negedge clk);
    msg_valid = 0; close = 0;
    n_checks++;
    if (ct_out !== 64'hFDFDFDFDFDFDFDFD || ct_valid !== 1'b1 || busy !== 1'b0 || msg_ready !== 1'b0 || pub_valid !== 1'b0) begin
      n_fail++; $display("FAIL close_with_msg: got ct %h v%b busy %b rdy %b pv %b", ct_out, ct_valid, busy, msg_ready, pub_valid);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    start_sess(5, 23, 6);
    for (k = 0; k < 40 && !pub_valid; k++) @(negedge clk);
    peer_pub = 19; peer_valid = 1;
    @(negedge clk);
    peer_valid = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || msg_ready !== 1'b0) begin n_fail++; $display("FAIL in_gen_key: got busy %b rdy %b want 1/0", busy, msg_ready); end
    rst = 1;
    @(negedge clk);
    rst = 0;
    n_checks++;
    if ({pub_out, pub_valid, msg_ready, ct_out, ct_valid, busy, timeout_err, cfg_err} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got %h want 0", {pub_out, pub_valid, msg_ready, ct_out, ct_valid, busy, timeout_err, cfg_err});
    end
  endtask

  task automatic test_timeout();
    int k;
    start_sess(5, 23, 6);
    for (k = 0; k < 40 && !pub_valid; k++) @(negedge clk);
    n_checks++;
    if (pub_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_pub: got %b want 1", pub_valid); end
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (timeout_err !== (i == 16)) begin n_fail++; $display("FAIL timeout_err: cycle %0d got %b want %b", i, timeout_err, i == 16); end
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || pub_valid !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL after_timeout: got busy %b pv %b te %b want 0", busy, pub_valid, timeout_err); end
  endtask

  task automatic test_early_peer();
    int k;
    start_sess(5, 23, 6);
    @(negedge clk);
    peer_pub = 19; peer_valid = 1;
    @(negedge clk);
    peer_valid = 0;
    repeat (2) @(negedge clk);
    peer_pub = 7; peer_valid = 1;
    for (k = 0; k < 60 && !msg_ready; k++) @(negedge clk);
    peer_valid = 0;
    n_checks++;
    if (msg_ready !== 1'b1 || pub_out !== 8'd8) begin n_fail++; $display("FAIL early_ready: got rdy %b pub %0d want 1/8", msg_ready, pub_out); end
    msg_in = 64'h0; msg_valid = 1;
    @(negedge clk);
    msg_valid = 0;
    n_checks++;
    if (ct_out !== KS2 || ct_valid !== 1'b1) begin n_fail++; $display("FAIL early_peer_key: got %h/%b want %h/1", ct_out, ct_valid, KS2); end
    close = 1;
    @(negedge clk);
    close = 0;
    n_checks++;
    if (busy !== 1'b0 || ct_valid !== 1'b0 || pub_out !== 8'd0) begin n_fail++; $display("FAIL close: got busy %b v %b pub %0d want 0", busy, ct_valid, pub_out); end
  endtask

  task automatic test_cfg_err();
    start_sess(5, 1, 6);
    n_checks++;
    if (cfg_err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err: got %b busy %b want 1/0", cfg_err, busy); end
    @(negedge clk);
    n_checks++;
    if (cfg_err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL cfg_err_pulse: got %b busy %b want 0/0", cfg_err, busy); end
  endtask

  task automatic test_freeze();
    start_sess(5, 23, 6);
    repeat (2) @(negedge clk);
    ena = 0;
    for (int i = 4; i <= 16; i++) begin
      @(negedge clk);
      n_checks++;
      if (pub_valid !== (i == 16) || busy !== 1'b1) begin n_fail++; $display("FAIL freeze: cycle %0d got pv %b busy %b want %b/1", i, pub_valid, busy, i == 16); end
      if (i == 8) ena = 1;
    end
    n_checks++;
    if (pub_out !== 8'd8) begin n_fail++; $display("FAIL freeze_pub: got %0d want 8", pub_out); end
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_pub_key();
    test_reset_mid();
    test_timeout();
    test_early_peer();
    test_cfg_err();
    test_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, timed out");
    $fatal(1);
  end
endmodule
